// File: rtl/util_cpack2_timestamp_pkg.sv
// Shared constants and types for the cpack2 timestamp packer.
package util_cpack2_timestamp_pkg;

  localparam int unsigned TS_LSB  = 0;
  localparam int unsigned SEQ_LSB = 64;

  typedef enum logic {StIdle, StInBlock} state_e;

  function automatic int unsigned lanes_per_beat(input int unsigned packed_width,
                                                 input int unsigned sample_width);
    return packed_width / sample_width;
  endfunction

endpackage

// File: rtl/util_cpack2_timestamp_lane_packer.sv
// Compacts the enabled channels of each strobe and accumulates them into output lanes.
module util_cpack2_timestamp_lane_packer
  import util_cpack2_timestamp_pkg::*;
#(
  parameter int unsigned NUM_OF_CHANNELS   = 4,
  parameter int unsigned SAMPLE_DATA_WIDTH = 16,
  parameter int unsigned PACKED_WIDTH      = 128
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              strobe_i,
  input  logic                                              flush_i,
  input  logic [NUM_OF_CHANNELS-1:0]                        enable_i,
  input  logic [NUM_OF_CHANNELS-1:0][SAMPLE_DATA_WIDTH-1:0] data_i,
  output logic                                              beat_done_o,
  output logic [PACKED_WIDTH-1:0]                           beat_data_o,
  output logic                                              flush_request_o,
  output logic [PACKED_WIDTH-1:0]                           flush_data_o
);

  localparam int unsigned Lanes = lanes_per_beat(PACKED_WIDTH, SAMPLE_DATA_WIDTH);
  localparam int unsigned CntW  = $clog2(2 * Lanes);

  typedef logic [Lanes-1:0][SAMPLE_DATA_WIDTH-1:0] beat_t;

  beat_t                                     lane_q, lane_d;
  logic [CntW-1:0]                           cnt_q, cnt_d;
  logic [2*Lanes-1:0][SAMPLE_DATA_WIDTH-1:0] ext;
  beat_t                                     ext_lo, ext_hi;
  logic [CntW-1:0]                           pos, rem;
  logic                                      done;

  // Two beats of scratch space: a strobe can finish one beat and spill into the next.
  always_comb begin
    ext = '0;
    ext[Lanes-1:0] = lane_q;
    pos = cnt_q;
    for (int c = 0; c < NUM_OF_CHANNELS; c++) begin
      if (enable_i[c]) begin
        ext[pos] = data_i[c];
        pos = pos + CntW'(1);
      end
    end
    ext_lo = ext[Lanes-1:0];
    ext_hi = ext[2*Lanes-1:Lanes];
    done   = strobe_i && (pos >= CntW'(Lanes));
    rem    = done ? pos - CntW'(Lanes) : pos;

    beat_done_o     = done;
    beat_data_o     = ext_lo;
    flush_request_o = strobe_i && flush_i && (rem != '0);
    flush_data_o    = done ? ext_hi : ext_lo;

    lane_d = lane_q;
    cnt_d  = cnt_q;
    if (strobe_i) begin
      if (flush_i) begin
        lane_d = '0;
        cnt_d  = '0;
      end else begin
        lane_d = done ? ext_hi : ext_lo;
        cnt_d  = rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      cnt_q  <= '0;
    end else begin
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/util_cpack2_timestamp.sv
// Packs enabled ADC channels into wide beats with a timestamp header per block of sample sets.
// Optional macro CPACK2_TS_BLOCK_COUNT_EN adds a header sequence number in bits [95:64].
module util_cpack2_timestamp
  import util_cpack2_timestamp_pkg::*;
#(
  parameter int unsigned NUM_OF_CHANNELS   = 4,
  parameter int unsigned SAMPLE_DATA_WIDTH = 16,
  parameter int unsigned PACKED_WIDTH      = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_0,
  input  logic                         enable_1,
  input  logic                         enable_2,
  input  logic                         enable_3,
  input  logic [63:0]                  timestamp,
  input  logic [31:0]                  timestamp_every,
  input  logic                         fifo_wr_en,
  input  logic [SAMPLE_DATA_WIDTH-1:0] fifo_wr_data_0,
  input  logic [SAMPLE_DATA_WIDTH-1:0] fifo_wr_data_1,
  input  logic [SAMPLE_DATA_WIDTH-1:0] fifo_wr_data_2,
  input  logic [SAMPLE_DATA_WIDTH-1:0] fifo_wr_data_3,
  output logic                         fifo_wr_overflow,
  output logic                         packed_fifo_wr_en,
  output logic [PACKED_WIDTH-1:0]      packed_fifo_wr_data,
  output logic                         packed_fifo_wr_sync
);

  logic [3:0]                        enable_all;
  logic [3:0][SAMPLE_DATA_WIDTH-1:0] data_all;
  logic [NUM_OF_CHANNELS-1:0]        en_q;
  logic [31:0]                       every_q;
  state_e                            state_q, state_d;
  logic [31:0]                       blk_cnt_q, blk_cnt_d;
  logic                              hold_valid_q, hold_valid_d;
  logic [PACKED_WIDTH-1:0]           hold_data_q, hold_data_d;
  logic                              out_en_d, out_sync_d, ovf_d;
  logic [PACKED_WIDTH-1:0]           out_data_d, hdr_data;
  logic                              strobe, hdr_due, last_strobe;
  logic                              beat_done, flush_req;
  logic [PACKED_WIDTH-1:0]           beat_data, flush_data;
`ifdef CPACK2_TS_BLOCK_COUNT_EN
  logic [31:0]                       seq_q, seq_d;
`endif

  assign enable_all = {enable_3, enable_2, enable_1, enable_0};
  assign data_all   = {fifo_wr_data_3, fifo_wr_data_2, fifo_wr_data_1, fifo_wr_data_0};
  assign strobe     = fifo_wr_en && (en_q != '0);
  assign hdr_due    = strobe && (state_q == StIdle) && (every_q != 32'd0);
  assign last_strobe = strobe && (every_q != 32'd0) &&
                       (((state_q == StIdle) && (every_q == 32'd1)) ||
                        ((state_q == StInBlock) && (blk_cnt_q + 32'd1 == every_q)));

  util_cpack2_timestamp_lane_packer #(
    .NUM_OF_CHANNELS  (NUM_OF_CHANNELS),
    .SAMPLE_DATA_WIDTH(SAMPLE_DATA_WIDTH),
    .PACKED_WIDTH     (PACKED_WIDTH)
  ) u_lane_packer (
    .clk            (clk),
    .reset          (reset),
    .strobe_i       (strobe),
    .flush_i        (last_strobe),
    .enable_i       (en_q),
    .data_i         (data_all[NUM_OF_CHANNELS-1:0]),
    .beat_done_o    (beat_done),
    .beat_data_o    (beat_data),
    .flush_request_o(flush_req),
    .flush_data_o   (flush_data)
  );

  always_comb begin
    hdr_data = '0;
    hdr_data[TS_LSB +: 64] = timestamp;
`ifdef CPACK2_TS_BLOCK_COUNT_EN
    hdr_data[SEQ_LSB +: 32] = seq_q;
    seq_d = hdr_due ? seq_q + 32'd1 : seq_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    if (strobe && (every_q != 32'd0)) begin
      if (state_q == StIdle) begin
        blk_cnt_d = 32'd1;
        state_d   = (every_q == 32'd1) ? StIdle : StInBlock;
      end else begin
        blk_cnt_d = blk_cnt_q + 32'd1;
        if (blk_cnt_q + 32'd1 == every_q) state_d = StIdle;
      end
    end
  end

  // Output arbitration: a pending held beat wins and blocks every new beat that cycle.
  always_comb begin
    out_en_d     = 1'b0;
    out_sync_d   = 1'b0;
    out_data_d   = '0;
    hold_valid_d = 1'b0;
    hold_data_d  = hold_data_q;
    ovf_d        = fifo_wr_overflow;
    if (hold_valid_q) begin
      out_en_d   = 1'b1;
      out_data_d = hold_data_q;
      if (hdr_due || beat_done || flush_req) ovf_d = 1'b1;
    end else if (hdr_due) begin
      out_en_d   = 1'b1;
      out_sync_d = 1'b1;
      out_data_d = hdr_data;
      if (beat_done) begin
        hold_valid_d = 1'b1;
        hold_data_d  = beat_data;
        if (flush_req) ovf_d = 1'b1;
      end else if (flush_req) begin
        hold_valid_d = 1'b1;
        hold_data_d  = flush_data;
      end
    end else if (beat_done) begin
      out_en_d   = 1'b1;
      out_data_d = beat_data;
      if (flush_req) begin
        hold_valid_d = 1'b1;
        hold_data_d  = flush_data;
      end
    end else if (flush_req) begin
      out_en_d   = 1'b1;
      out_data_d = flush_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q                <= enable_all[NUM_OF_CHANNELS-1:0];
      every_q             <= timestamp_every;
      state_q             <= StIdle;
      blk_cnt_q           <= '0;
      hold_valid_q        <= 1'b0;
      hold_data_q         <= '0;
      packed_fifo_wr_en   <= 1'b0;
      packed_fifo_wr_data <= '0;
      packed_fifo_wr_sync <= 1'b0;
      fifo_wr_overflow    <= 1'b0;
`ifdef CPACK2_TS_BLOCK_COUNT_EN
      seq_q               <= '0;
`endif
    end else begin
      state_q             <= state_d;
      blk_cnt_q           <= blk_cnt_d;
      hold_valid_q        <= hold_valid_d;
      hold_data_q         <= hold_data_d;
      packed_fifo_wr_en   <= out_en_d;
      packed_fifo_wr_data <= out_data_d;
      packed_fifo_wr_sync <= out_sync_d;
      fifo_wr_overflow    <= ovf_d;
`ifdef CPACK2_TS_BLOCK_COUNT_EN
      seq_q               <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_util_cpack2_timestamp.sv
// Directed bench for util_cpack2_timestamp with hand-computed beats.
module tb_util_cpack2_timestamp;

`ifdef CPACK2_TS_BLOCK_COUNT_EN
  localparam bit SeqEn = 1'b1;
`else
  localparam bit SeqEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable_0 = 1'b0, enable_1 = 1'b0, enable_2 = 1'b0, enable_3 = 1'b0;
  logic [63:0]  timestamp = '0;
  logic [31:0]  timestamp_every = '0;
  logic         fifo_wr_en = 1'b0;
  logic [15:0]  fifo_wr_data_0 = '0, fifo_wr_data_1 = '0, fifo_wr_data_2 = '0;
  logic [15:0]  fifo_wr_data_3 = '0;
  logic         fifo_wr_overflow;
  logic         packed_fifo_wr_en;
  logic [127:0] packed_fifo_wr_data;
  logic         packed_fifo_wr_sync;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [127:0] q_data[$];
  logic         q_sync[$];

  always #5 clk = ~clk;

  util_cpack2_timestamp dut (
    .clk                (clk),
    .reset              (reset),
    .enable_0           (enable_0),
    .enable_1           (enable_1),
    .enable_2           (enable_2),
    .enable_3           (enable_3),
    .timestamp          (timestamp),
    .timestamp_every    (timestamp_every),
    .fifo_wr_en         (fifo_wr_en),
    .fifo_wr_data_0     (fifo_wr_data_0),
    .fifo_wr_data_1     (fifo_wr_data_1),
    .fifo_wr_data_2     (fifo_wr_data_2),
    .fifo_wr_data_3     (fifo_wr_data_3),
    .fifo_wr_overflow   (fifo_wr_overflow),
    .packed_fifo_wr_en  (packed_fifo_wr_en),
    .packed_fifo_wr_data(packed_fifo_wr_data),
    .packed_fifo_wr_sync(packed_fifo_wr_sync)
  );

  always @(negedge clk) begin
    if (packed_fifo_wr_en) begin
      q_data.push_back(packed_fifo_wr_data);
      q_sync.push_back(packed_fifo_wr_sync);
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [127:0] d,
                            input logic s);
    if (idx < q_data.size()) begin
      check_eq({tag, "_data"}, q_data[idx], d);
      check_eq({tag, "_sync"}, 128'(q_sync[idx]), 128'(s));
    end else begin
      check_eq({tag, "_present"}, 128'(q_data.size()), 128'(idx + 1));
    end
  endtask

  function automatic logic [127:0] hdr(input logic [63:0] ts, input logic [31:0] seq);
    logic [127:0] h;
    h = '0;
    h[63:0]  = ts;
    h[95:64] = SeqEn ? seq : 32'h0;
    return h;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [31:0] every);
    {enable_3, enable_2, enable_1, enable_0} = en;
    timestamp_every = every;
    fifo_wr_en = 1'b0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] d3, input logic [63:0] ts);
    fifo_wr_data_0 = d0;
    fifo_wr_data_1 = d1;
    fifo_wr_data_2 = d2;
    fifo_wr_data_3 = d3;
    timestamp = ts;
    fifo_wr_en = 1'b1;
    cycles(1);
    fifo_wr_en = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_sync.delete();
  endtask

  initial begin
    #1;
    // All four channels, no headers: two strobes fill one beat.
    do_reset(4'b1111, 32'd0);
    check_eq("rst_en", 128'(packed_fifo_wr_en), 128'd0);
    check_eq("rst_data", packed_fifo_wr_data, 128'd0);
    check_eq("rst_sync", 128'(packed_fifo_wr_sync), 128'd0);
    check_eq("rst_ovf", 128'(fifo_wr_overflow), 128'd0);
    strobe(16'd1, 16'd2, 16'd3, 16'd4, 64'd0);
    check_eq("t1_en_early", 128'(packed_fifo_wr_en), 128'd0);
    strobe(16'd5, 16'd6, 16'd7, 16'd8, 64'd0);
    check_eq("t1_en", 128'(packed_fifo_wr_en), 128'd1);
    check_eq("t1_data", packed_fifo_wr_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check_eq("t1_sync", 128'(packed_fifo_wr_sync), 128'd0);
    cycles(1);
    check_eq("t1_en_pulse", 128'(packed_fifo_wr_en), 128'd0);

    // Channels 0 and 2 only.
    do_reset(4'b0101, 32'd0);
    clear_q();
    for (int s = 0; s < 4; s++) begin
      strobe(16'(16'h00A0 + s), 16'(16'h00B0 + s), 16'(16'h00C0 + s), 16'(16'h00D0 + s),
             64'd0);
    end
    cycles(2);
    check_eq("t2_count", 128'(q_data.size()), 128'd1);
    check_beat("t2_b0", 0, 128'h00C3_00A3_00C2_00A2_00C1_00A1_00C0_00A0, 1'b0);

    // Blocks of four sample sets.
    do_reset(4'b1111, 32'd4);
    clear_q();
    for (int s = 0; s < 5; s++) begin
      strobe(16'(16'h0100 + 16 * s), 16'(16'h0101 + 16 * s), 16'(16'h0102 + 16 * s),
             16'(16'h0103 + 16 * s), (s == 4) ? 64'h2000 : 64'(64'h1000 + s));
    end
    cycles(2);
    check_eq("t3_count", 128'(q_data.size()), 128'd4);
    check_beat("t3_hdr0", 0, hdr(64'h1000, 32'd0), 1'b1);
    check_beat("t3_b1", 1, 128'h0113_0112_0111_0110_0103_0102_0101_0100, 1'b0);
    check_beat("t3_b2", 2, 128'h0133_0132_0131_0130_0123_0122_0121_0120, 1'b0);
    check_beat("t3_hdr1", 3, hdr(64'h2000, 32'd1), 1'b1);

    // Single channel, block of three: partial beat flushed.
    do_reset(4'b0001, 32'd3);
    clear_q();
    for (int s = 1; s <= 3; s++) begin
      strobe(16'(16'h0A00 + s), 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'(64'h54 + s));
    end
    cycles(2);
    check_eq("t4_count", 128'(q_data.size()), 128'd2);
    check_beat("t4_hdr", 0, hdr(64'h55, 32'd0), 1'b1);
    check_beat("t4_flush", 1, 128'h0A03_0A02_0A01, 1'b0);

    // Every set is a block: header/flush pairs collide and overflow.
    do_reset(4'b1111, 32'd1);
    strobe(16'd1, 16'd2, 16'd3, 16'd4, 64'h10);
    check_eq("t5_e1_en", 128'(packed_fifo_wr_en), 128'd1);
    check_eq("t5_e1_sync", 128'(packed_fifo_wr_sync), 128'd1);
    check_eq("t5_e1_data", packed_fifo_wr_data, hdr(64'h10, 32'd0));
    check_eq("t5_e1_ovf", 128'(fifo_wr_overflow), 128'd0);
    strobe(16'd5, 16'd6, 16'd7, 16'd8, 64'h20);
    check_eq("t5_e2_sync", 128'(packed_fifo_wr_sync), 128'd0);
    check_eq("t5_e2_data", packed_fifo_wr_data, 128'h0004_0003_0002_0001);
    check_eq("t5_e2_ovf", 128'(fifo_wr_overflow), 128'd1);
    strobe(16'd9, 16'd10, 16'd11, 16'd12, 64'h30);
    check_eq("t5_e3_data", packed_fifo_wr_data, hdr(64'h30, 32'd2));
    strobe(16'd13, 16'd14, 16'd15, 16'd16, 64'h40);
    cycles(4);
    check_eq("t5_ovf_sticky", 128'(fifo_wr_overflow), 128'd1);
    check_eq("t5_idle_en", 128'(packed_fifo_wr_en), 128'd0);
    do_reset(4'b1111, 32'd0);
    check_eq("t5_ovf_cleared", 128'(fifo_wr_overflow), 128'd0);

    // Reset in the middle of a block discards the partial beat.
    do_reset(4'b0001, 32'd4);
    clear_q();
    for (int s = 1; s <= 3; s++) begin
      strobe(16'(16'h0C00 + s), 16'h0, 16'h0, 16'h0, 64'(64'h60 + s));
    end
    cycles(1);
    do_reset(4'b0001, 32'd4);
    cycles(2);
    check_eq("t6_no_flush", 128'(q_data.size()), 128'd1);
    clear_q();
    for (int s = 1; s <= 4; s++) begin
      strobe(16'(16'h0B00 + s), 16'h0, 16'h0, 16'h0, (s == 1) ? 64'h77 : 64'h99);
    end
    cycles(2);
    check_eq("t6_count", 128'(q_data.size()), 128'd2);
    check_beat("t6_hdr", 0, hdr(64'h77, 32'd0), 1'b1);
    check_beat("t6_flush", 1, 128'h0B04_0B03_0B02_0B01, 1'b0);

    // No channel enabled: strobes are ignored.
    do_reset(4'b0000, 32'd2);
    clear_q();
    for (int s = 0; s < 4; s++) strobe(16'h1111, 16'h2222, 16'h3333, 16'h4444, 64'h5);
    cycles(2);
    check_eq("t7_count", 128'(q_data.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
